// File: rtl/cv32e40x_instr_bus_adapter_if.sv
// Bundle of the prefetcher-side transaction handshake, the response path back
// to the prefetcher and the OBI instruction bus. The adapter uses the slave
// view; the surrounding environment (prefetcher + bus) uses the master view.
interface cv32e40x_instr_bus_adapter_if;
  // prefetcher transaction request
  logic        trans_valid;
  logic        trans_ready;
  logic [31:0] trans_addr;
  logic        fetch_branch;
  // response forwarded to prefetcher
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  // OBI instruction bus
  logic        obi_req;
  logic        obi_gnt;
  logic [31:0] obi_addr;
  logic        obi_rvalid;
  logic [31:0] obi_rdata;
  logic        obi_err;

  modport slave (
    input  trans_valid, trans_addr, fetch_branch,
    output trans_ready,
    output resp_valid, resp_rdata, resp_err,
    output obi_req, obi_addr,
    input  obi_gnt, obi_rvalid, obi_rdata, obi_err
  );

  modport master (
    output trans_valid, trans_addr, fetch_branch,
    input  trans_ready,
    input  resp_valid, resp_rdata, resp_err,
    input  obi_req, obi_addr,
    output obi_gnt, obi_rvalid, obi_rdata, obi_err
  );
endinterface

// File: rtl/cv32e40x_instr_bus_adapter.sv
// Instruction bus adapter: turns the prefetcher's unstable transaction request
// into an OBI request that stays put until granted, tracks outstanding
// transactions and drops responses of fetches killed by a taken branch.
module cv32e40x_instr_bus_adapter #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  cv32e40x_instr_bus_adapter_if.slave        bus
);

  localparam int unsigned     CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

  typedef enum logic {TRANSPARENT, REGISTERED} state_e;

  state_e        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic          stale_q, stale_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic          req;
  logic          ready;
  logic [31:0]   addr_out;
  logic [31:0]   addr_aligned;
  logic          gnt_fire;
  logic          reg_gnt;
  logic          drop_now;

  // Masking keeps all trans_addr bits in use while forcing word alignment.
  assign addr_aligned = bus.trans_addr & 32'hFFFF_FFFC;

  // Request/address mux and hold-until-grant state machine.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    stale_d  = stale_q;
    req      = 1'b0;
    ready    = 1'b0;
    addr_out = addr_aligned;
    unique case (state_q)
      TRANSPARENT: begin
        // Limit is on out_cnt alone: a same-cycle rvalid does not free a slot.
        req      = bus.trans_valid && (out_cnt_q < DEPTH_C);
        addr_out = addr_aligned;
        ready    = req && bus.obi_gnt;
        if (req && !bus.obi_gnt) begin
          state_d = REGISTERED;
          addr_d  = addr_aligned;
          stale_d = bus.fetch_branch;
        end
      end
      REGISTERED: begin
        // Prefetcher is never acked here; it replays its (new) target later.
        req      = 1'b1;
        addr_out = addr_q;
        ready    = 1'b0;
        if (bus.obi_gnt) begin
          state_d = TRANSPARENT;
          stale_d = 1'b0;
        end else if (bus.fetch_branch) begin
          stale_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign gnt_fire = req && bus.obi_gnt;
  assign reg_gnt  = (state_q == REGISTERED) && bus.obi_gnt;
  assign drop_now = bus.obi_rvalid && ((drop_cnt_q != '0) || bus.fetch_branch);

  // Outstanding and to-be-dropped transaction counters.
  always_comb begin
    out_cnt_d = out_cnt_q + CW'(gnt_fire) - CW'(bus.obi_rvalid);
    if (bus.fetch_branch) begin
      // Everything still in flight is now obsolete, plus a held request that
      // gets granted this cycle. A transparent grant here is the branch target.
      drop_cnt_d = out_cnt_q - CW'(bus.obi_rvalid) + CW'(reg_gnt);
    end else begin
      drop_cnt_d = drop_cnt_q - CW'(bus.obi_rvalid && (drop_cnt_q != '0))
                 + CW'(reg_gnt && stale_q);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= TRANSPARENT;
      addr_q     <= '0;
      stale_q    <= 1'b0;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      stale_q    <= stale_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.obi_req     = req;
  assign bus.obi_addr    = addr_out;
  assign bus.trans_ready = ready;
  assign bus.resp_valid  = bus.obi_rvalid && !drop_now;
  assign bus.resp_rdata  = bus.obi_rdata;
  assign bus.resp_err    = bus.obi_err;

  // Bus protocol and internal invariants.
  a_no_rvalid_idle: assert property (@(posedge clk) disable iff (!rst_n)
    bus.obi_rvalid |-> (out_cnt_q != '0));
  a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.obi_req && !bus.obi_gnt) |=> (bus.obi_req && (bus.obi_addr == $past(bus.obi_addr))));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    out_cnt_q <= DEPTH_C);
  a_drop_le_out: assert property (@(posedge clk) disable iff (!rst_n)
    drop_cnt_q <= out_cnt_q);

endmodule

// File: tb/tb_cv32e40x_instr_bus_adapter.sv
// Bench for the instruction bus adapter: directed vector table, a reset
// sequence, then random traffic against a transaction-queue model.
module tb_cv32e40x_instr_bus_adapter;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cv32e40x_instr_bus_adapter_if bus();

  cv32e40x_instr_bus_adapter #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        tv;
    logic [31:0] ta;
    logic        br;
    logic        g;
    logic        rv;
    logic [31:0] rd;
    logic        er;
    logic        ereq;
    logic [31:0] eaddr;
    logic        erdy;
    logic        ervld;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic tv, logic [31:0] ta, logic br, logic g, logic rv,
                              logic [31:0] rd, logic er, logic ereq, logic [31:0] ea,
                              logic erdy, logic ervld);
    vec_t v;
    v.tv = tv; v.ta = ta; v.br = br; v.g = g; v.rv = rv; v.rd = rd; v.er = er;
    v.ereq = ereq; v.eaddr = ea; v.erdy = erdy; v.ervld = ervld;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.trans_valid  = v.tv;
    bus.trans_addr   = v.ta;
    bus.fetch_branch = v.br;
    bus.obi_gnt      = v.g;
    bus.obi_rvalid   = v.rv;
    bus.obi_rdata    = v.rd;
    bus.obi_err      = v.er;
  endtask

  // Drive one cycle, check outputs at the falling edge, then advance.
  task automatic apply(input vec_t v, input string tag);
    drive(v);
    @(negedge clk);
    chk({tag, ".req"},   32'(bus.obi_req),     32'(v.ereq));
    chk({tag, ".addr"},  bus.obi_addr,         v.eaddr);
    chk({tag, ".ready"}, 32'(bus.trans_ready), 32'(v.erdy));
    chk({tag, ".rvld"},  32'(bus.resp_valid),  32'(v.ervld));
    if (v.rv) begin
      chk({tag, ".rdata"}, bus.resp_rdata,     v.rd);
      chk({tag, ".err"},   32'(bus.resp_err),  32'(v.er));
    end
    @(posedge clk);
    #1;
  endtask

  // Reference model: queue of outstanding transactions, each tagged with
  // whether its response must be discarded, plus a held (ungranted) request.
  bit          kq[$];
  bit          pend;
  logic [31:0] pend_addr;
  bit          pend_stale;

  task automatic model_reset();
    kq.delete();
    pend = 0;
    pend_addr = '0;
    pend_stale = 0;
  endtask

  task automatic random_cycle(input int idx);
    vec_t v;
    bit   drop;
    v.tv = ($urandom_range(0, 9) < 7);
    v.ta = $urandom();
    v.br = ($urandom_range(0, 7) == 0);
    v.g  = ($urandom_range(0, 9) < 6);
    v.rv = (kq.size() > 0) && ($urandom_range(0, 1) == 1);
    v.rd = $urandom();
    v.er = ($urandom_range(0, 3) == 0);
    v.ereq  = pend ? 1'b1 : (v.tv && (kq.size() < DEPTH));
    v.eaddr = pend ? pend_addr : {v.ta[31:2], 2'b00};
    v.erdy  = !pend && v.ereq && v.g;
    drop    = v.rv && (kq[0] || v.br);
    v.ervld = v.rv && !drop;
    apply(v, $sformatf("rnd%0d", idx));
    if (v.rv) void'(kq.pop_front());
    if (v.br) foreach (kq[i]) kq[i] = 1;
    if (v.ereq && v.g) kq.push_back(pend ? (pend_stale || v.br) : 1'b0);
    if (pend) begin
      if (v.g) pend = 0;
      else if (v.br) pend_stale = 1;
    end else if (v.ereq && !v.g) begin
      pend = 1;
      pend_addr = v.eaddr;
      pend_stale = v.br;
    end
  endtask

  initial begin
    // Reset state: transparent, counters zero.
    drive(mk(1, 32'h13, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("rst.req",   32'(bus.obi_req),     32'd1);
    chk("rst.addr",  bus.obi_addr,         32'h10);
    chk("rst.ready", 32'(bus.trans_ready), 32'd0);
    chk("rst.rvld",  32'(bus.resp_valid),  32'd0);
    chk("rst.out",   32'(dut.out_cnt_q),   32'd0);
    chk("rst.drop",  32'(dut.drop_cnt_q),  32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    //            tv ta          br g rv rd          er  req eaddr      rdy rvld
    tbl.push_back(mk(1, 32'h100, 0, 1, 0, 32'h0,     0,  1, 32'h100, 1, 0));
    tbl.push_back(mk(1, 32'h104, 0, 1, 0, 32'h0,     0,  1, 32'h104, 1, 0));
    tbl.push_back(mk(1, 32'h108, 0, 1, 0, 32'h0,     0,  0, 32'h108, 0, 0));
    tbl.push_back(mk(1, 32'h108, 0, 0, 1, 32'hAAAA,  0,  0, 32'h108, 0, 1));
    tbl.push_back(mk(1, 32'h109, 0, 1, 1, 32'hBBBB,  0,  1, 32'h108, 1, 1));
    tbl.push_back(mk(0, 32'h10C, 0, 0, 1, 32'hCCCC,  0,  0, 32'h10C, 0, 1));
    tbl.push_back(mk(1, 32'h200, 0, 0, 0, 32'h0,     0,  1, 32'h200, 0, 0));
    tbl.push_back(mk(1, 32'h250, 0, 0, 0, 32'h0,     0,  1, 32'h200, 0, 0));
    tbl.push_back(mk(1, 32'h300, 0, 0, 0, 32'h0,     0,  1, 32'h200, 0, 0));
    tbl.push_back(mk(1, 32'h300, 0, 1, 0, 32'h0,     0,  1, 32'h200, 0, 0));
    tbl.push_back(mk(1, 32'h300, 0, 1, 0, 32'h0,     0,  1, 32'h300, 1, 0));
    tbl.push_back(mk(1, 32'h400, 1, 1, 0, 32'h0,     0,  0, 32'h400, 0, 0));
    tbl.push_back(mk(1, 32'h400, 0, 1, 1, 32'hD1,    0,  0, 32'h400, 0, 0));
    tbl.push_back(mk(1, 32'h400, 0, 1, 1, 32'hD2,    0,  1, 32'h400, 1, 0));
    tbl.push_back(mk(0, 32'h0,   0, 0, 1, 32'hD3,    0,  0, 32'h0,   0, 1));
    tbl.push_back(mk(1, 32'h500, 0, 0, 0, 32'h0,     0,  1, 32'h500, 0, 0));
    tbl.push_back(mk(1, 32'h800, 1, 0, 0, 32'h0,     0,  1, 32'h500, 0, 0));
    tbl.push_back(mk(1, 32'h800, 0, 1, 0, 32'h0,     0,  1, 32'h500, 0, 0));
    tbl.push_back(mk(1, 32'h800, 0, 1, 0, 32'h0,     0,  1, 32'h800, 1, 0));
    tbl.push_back(mk(0, 32'h0,   0, 0, 1, 32'h5555,  0,  0, 32'h0,   0, 0));
    tbl.push_back(mk(0, 32'h0,   0, 0, 1, 32'h8888,  0,  0, 32'h0,   0, 1));
    tbl.push_back(mk(1, 32'h900, 0, 1, 0, 32'h0,     0,  1, 32'h900, 1, 0));
    tbl.push_back(mk(1, 32'hA00, 1, 1, 1, 32'hEEEE,  1,  1, 32'hA00, 1, 0));
    tbl.push_back(mk(0, 32'h0,   0, 0, 1, 32'hF00D,  1,  0, 32'h0,   0, 1));
    tbl.push_back(mk(1, 32'hB00, 0, 1, 0, 32'h0,     0,  1, 32'hB00, 1, 0));
    tbl.push_back(mk(1, 32'hB04, 0, 1, 0, 32'h0,     0,  1, 32'hB04, 1, 0));
    tbl.push_back(mk(1, 32'hC00, 1, 1, 0, 32'h0,     0,  0, 32'hC00, 0, 0));
    tbl.push_back(mk(1, 32'hD00, 1, 1, 1, 32'h1,     0,  0, 32'hD00, 0, 0));
    tbl.push_back(mk(0, 32'h0,   0, 0, 1, 32'h2,     0,  0, 32'h0,   0, 0));
    foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

    // Reset mid-transaction with out_cnt=2, drop_cnt=1.
    apply(mk(1, 32'hE00, 0, 1, 0, 32'h0, 0, 1, 32'hE00, 1, 0), "r6a");
    apply(mk(1, 32'hE10, 1, 1, 0, 32'h0, 0, 1, 32'hE10, 1, 0), "r6b");
    chk("r6.pre_out",  32'(dut.out_cnt_q),  32'd2);
    chk("r6.pre_drop", 32'(dut.drop_cnt_q), 32'd1);
    drive(mk(1, 32'h123, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    #1;
    chk("r6.out",  32'(dut.out_cnt_q),  32'd0);
    chk("r6.drop", 32'(dut.drop_cnt_q), 32'd0);
    @(negedge clk);
    chk("r6.req",  32'(bus.obi_req), 32'd1);
    chk("r6.addr", bus.obi_addr,     32'h120);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply(mk(1, 32'h600, 0, 1, 0, 32'h0,    0, 1, 32'h600, 1, 0), "r6c");
    apply(mk(1, 32'h604, 0, 1, 0, 32'h0,    0, 1, 32'h604, 1, 0), "r6d");
    apply(mk(1, 32'h608, 0, 1, 0, 32'h0,    0, 0, 32'h608, 0, 0), "r6e");
    apply(mk(0, 32'h0,   0, 0, 1, 32'h1234, 0, 0, 32'h0,   0, 1), "r6f");
    apply(mk(0, 32'h0,   0, 0, 1, 32'h5678, 1, 0, 32'h0,   0, 1), "r6g");

    // Random traffic against the model.
    drive(mk(0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3000; i++) random_cycle(i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
